bram_port_master: RTL and testbench
===================================

// Module: bram_port_master
// PURPOSE
// BRAM native-port initiator: the other end of the host_bram_* port that the kernel serves as a memory.
// Turns single-word write requests and incrementing read bursts on a valid/ready request channel into
// BRAM cycles (addr/en/we/din) and returns read words on a valid/ready response channel.
// Lets on-card logic read and write a BRAM-style memory the same way the XDMA BRAM controller does.
// PARAMETERS
// ADDR_W  15  byte-address width of bram_addr (32 KiB window)
// DATA_W  32  data width; DATA_W/8 byte enables
// RD_LAT  2   BRAM read latency in cycles, 1..7
// LEN_W   8   burst length field width; burst = req_len+1 words
// PORTS
// host_clk     in   1         single clock for all logic
// host_rstn    in   1         synchronous active-low reset
// req_valid    in   1         request valid
// req_ready    out  1         request accepted when valid&ready
// req_we       in   DATA_W/8  byte enables; nonzero = write 1 word, zero = read burst
// req_addr     in   ADDR_W    start byte address; bits [1:0] ignored (forced 0)
// req_len      in   LEN_W     read burst length-1; ignored for writes
// req_wdata    in   DATA_W    write data
// rsp_valid    out  1         read word valid
// rsp_ready    in   1         consumer accepts read word
// rsp_rdata    out  DATA_W    read word
// rsp_last     out  1         final word of burst
// bram_clk     out  1         = host_clk
// bram_rst     out  1         = ~host_rstn (active-high BRAM reset)
// bram_addr    out  ADDR_W    byte address, word-aligned
// bram_en      out  1         BRAM enable
// bram_we      out  DATA_W/8  BRAM byte write enables
// bram_din     out  DATA_W    BRAM write data
// bram_dout    in   DATA_W    BRAM read data, valid RD_LAT cycles after en
// BEHAVIOUR
// Reset (host_rstn=0 at edge): state=IDLE; req_ready, rsp_valid, rsp_last, bram_en=0; bram_we, bram_addr,
//   bram_din, rsp_rdata=0; beat and latency counters=0. Reset mid-burst abandons it; no rsp after reset.
// All outputs registered except bram_clk/bram_rst. req_ready=1 only in IDLE (and not in reset).
// FSM: IDLE, WR, RD_ISSUE, RD_WAIT, RD_RESP.
// IDLE: on req_valid&req_ready: latch addr (bits[1:0]=0), we, wdata, len.
//   req_we!=0 -> WR; req_we==0 -> RD_ISSUE.
// WR (1 cycle): bram_en=1, bram_we=latched we, bram_addr, bram_din driven; -> IDLE. No response.
//   Write throughput: one write per 2 cycles.
// RD_ISSUE (cycle T): bram_en=1, bram_we=0, bram_addr=current; -> RD_WAIT, lat counter=RD_LAT.
// RD_WAIT (cycles T+1..T+RD_LAT): bram_en=0; capture bram_dout into rsp_rdata at edge ending T+RD_LAT;
//   then -> RD_RESP with rsp_valid=1 from cycle T+RD_LAT+1; rsp_last=1 iff beats remaining==0.
// RD_RESP: hold rsp_valid/rsp_rdata/rsp_last stable until rsp_ready. On handshake: rsp_valid=0;
//   if last -> IDLE, else addr+=DATA_W/8 -> RD_ISSUE next cycle. One outstanding read at a time.
// Address arithmetic modulo 2^ADDR_W: burst crossing top wraps to 0 (0x7FFC -> 0x0000 at ADDR_W=15).
// bram_en never asserted outside WR/RD_ISSUE; bram_we nonzero only in WR.
// req_* inputs are don't-care outside IDLE; new request cannot be accepted in the cycle a burst ends.
// TESTING
// Reset: hold host_rstn=0 4 cycles with req_valid=1 -> req_ready=0, bram_en=0, rsp_valid=0 throughout.
// Write: we=4'hF, addr=0x0104, wdata=0xDEADBEEF -> next cycle en=1, we=F, addr=0x0104, din=DEADBEEF, 1 cycle.
// Read RD_LAT=2: model returns mem[0x10]=0x12345678 -> issue at T, rsp_valid at T+3, rsp_last=1.
// Burst len=3 at 0x0200, rsp_ready toggled 1/0 -> 4 words from 0x200,0x204,0x208,0x20C in order,
//   rdata stable while stalled, rsp_last only on 4th.
// Wrap: read len=1 at 0x7FFE -> addrs 0x7FFC then 0x0000.
// Reset mid-burst (after 2nd word, len=7) -> outputs at reset values next cycle, IDLE, req_ready=1 after release.

Source files
------------

// File: rtl/bram_port_master.sv
// BRAM native-port initiator: single-word writes and incrementing read bursts from a
// valid/ready request channel, read words returned on a valid/ready response channel.
module bram_port_master #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2,
  parameter int LEN_W  = 8
) (
  input  logic                host_clk,
  input  logic                host_rstn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [DATA_W/8-1:0] req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [LEN_W-1:0]    req_len,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_last,
  output logic                bram_clk,
  output logic                bram_rst,
  output logic [ADDR_W-1:0]   bram_addr,
  output logic                bram_en,
  output logic [DATA_W/8-1:0] bram_we,
  output logic [DATA_W-1:0]   bram_din,
  input  logic [DATA_W-1:0]   bram_dout
);

  localparam int BYTE_W = DATA_W / 8;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BYTE_W - 1);
  localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(BYTE_W);

  typedef enum logic [2:0] {IDLE, WR, RD_ISSUE, RD_WAIT, RD_RESP} state_t;

  state_t              state_q;
  logic                req_ready_q;
  logic                rsp_valid_q;
  logic                rsp_last_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                bram_en_q;
  logic [BYTE_W-1:0]   bram_we_q;
  logic [ADDR_W-1:0]   bram_addr_q;
  logic [DATA_W-1:0]   bram_din_q;
  logic [LEN_W-1:0]    beats_q;
  logic [2:0]          lat_q;
  logic [ADDR_W-1:0]   next_addr_d;

  // The address register doubles as the burst pointer; wraps modulo 2^ADDR_W.
  assign next_addr_d = bram_addr_q + ADDR_STEP;

  always_ff @(posedge host_clk) begin
    if (!host_rstn) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_rdata_q <= '0;
      bram_en_q   <= 1'b0;
      bram_we_q   <= '0;
      bram_addr_q <= '0;
      bram_din_q  <= '0;
      beats_q     <= '0;
      lat_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            bram_en_q   <= 1'b1;
            bram_we_q   <= req_we;
            bram_addr_q <= req_addr & ALIGN_MASK;
            bram_din_q  <= req_wdata;
            beats_q     <= req_len;
            state_q     <= (req_we != '0) ? WR : RD_ISSUE;
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        WR: begin
          bram_en_q   <= 1'b0;
          bram_we_q   <= '0;
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        RD_ISSUE: begin
          bram_en_q <= 1'b0;
          lat_q     <= 3'(RD_LAT);
          state_q   <= RD_WAIT;
        end
        // Counts down the BRAM pipeline; the final count is the capture edge.
        RD_WAIT: begin
          if (lat_q <= 3'd1) begin
            rsp_rdata_q <= bram_dout;
            rsp_valid_q <= 1'b1;
            rsp_last_q  <= (beats_q == '0);
            lat_q       <= '0;
            state_q     <= RD_RESP;
          end else begin
            lat_q <= lat_q - 3'd1;
          end
        end
        RD_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            if (rsp_last_q) begin
              req_ready_q <= 1'b1;
              state_q     <= IDLE;
            end else begin
              beats_q     <= beats_q - LEN_W'(1);
              bram_addr_q <= next_addr_d;
              bram_en_q   <= 1'b1;
              state_q     <= RD_ISSUE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_last  = rsp_last_q;
  assign bram_clk  = host_clk;
  assign bram_rst  = ~host_rstn;
  assign bram_addr = bram_addr_q;
  assign bram_en   = bram_en_q;
  assign bram_we   = bram_we_q;
  assign bram_din  = bram_din_q;

endmodule

// File: tb/tb_bram_port_master.sv
// Directed bench for bram_port_master with a byte-enabled BRAM model of latency RD_LAT.
// Unwritten words read back as {16'hC0DE, 1'b0, byte_address}.
module tb_bram_port_master;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 32;
  localparam int RD_LAT = 2;
  localparam int LEN_W  = 8;

  logic        hostClk = 1'b0;
  logic        hostRstn = 1'b0;
  logic        reqValid = 1'b0;
  logic        reqReady;
  logic [3:0]  reqWe = '0;
  logic [14:0] reqAddr = '0;
  logic [7:0]  reqLen = '0;
  logic [31:0] reqWdata = '0;
  logic        rspValid;
  logic        rspReady = 1'b0;
  logic [31:0] rspRdata;
  logic        rspLast;
  logic        bramClk;
  logic        bramRst;
  logic [14:0] bramAddr;
  logic        bramEn;
  logic [3:0]  bramWe;
  logic [31:0] bramDin;
  logic [31:0] bramDout;

  int passCount = 0;
  int checkCount = 0;

  logic [14:0] issued [16];
  logic [31:0] got [16];
  logic        gotLast [16];
  int          nIssued;
  int          nGot;

  bram_port_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .LEN_W(LEN_W)
  ) dut (
    .host_clk(hostClk), .host_rstn(hostRstn),
    .req_valid(reqValid), .req_ready(reqReady), .req_we(reqWe), .req_addr(reqAddr),
    .req_len(reqLen), .req_wdata(reqWdata),
    .rsp_valid(rspValid), .rsp_ready(rspReady), .rsp_rdata(rspRdata), .rsp_last(rspLast),
    .bram_clk(bramClk), .bram_rst(bramRst), .bram_addr(bramAddr), .bram_en(bramEn),
    .bram_we(bramWe), .bram_din(bramDin), .bram_dout(bramDout)
  );

  always #5 hostClk = ~hostClk;

  // BRAM model: written words kept in mem, others follow the address pattern.
  logic [31:0] mem [8192];
  logic        written [8192];
  logic [31:0] pipe [RD_LAT];

  function automatic logic [31:0] memRead(input logic [14:0] a);
    if (written[a[14:2]] === 1'b1) return mem[a[14:2]];
    return {16'hC0DE, 1'b0, a};
  endfunction

  function automatic logic [31:0] mergeWrite(input logic [31:0] old, input logic [31:0] din,
                                             input logic [3:0] we);
    logic [31:0] w;
    w = old;
    for (int b = 0; b < 4; b++) if (we[b]) w[8*b +: 8] = din[8*b +: 8];
    return w;
  endfunction

  always @(posedge hostClk) begin
    if (bramEn === 1'b1) begin
      if (bramWe != 4'h0) begin
        mem[bramAddr[14:2]]     <= mergeWrite(memRead(bramAddr), bramDin, bramWe);
        written[bramAddr[14:2]] <= 1'b1;
      end
      pipe[0] <= memRead(bramAddr);
    end
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end

  assign bramDout = pipe[RD_LAT-1];

  task automatic tick();
    @(posedge hostClk);
    #1;
  endtask

  // Waits (bounded) for req_ready, presents one request for one accepting edge.
  task automatic sendReq(input logic [3:0] we, input logic [14:0] addr, input logic [7:0] len,
                         input logic [31:0] wdata);
    int waitCycles;
    waitCycles = 0;
    while (reqReady !== 1'b1 && waitCycles < 50) begin
      tick();
      waitCycles++;
    end
    checkCount++; if (reqReady === 1'b1) passCount++;
    else $display("[TB] FAIL req_ready_wait: got %b expected 1", reqReady);
    reqValid = 1'b1; reqWe = we; reqAddr = addr; reqLen = len; reqWdata = wdata;
    tick();
    reqValid = 1'b0;
  endtask

  // Records issued addresses and received words; with stall=1 every word is held one cycle.
  task automatic collectRead(input int maxWords, input bit stall, input int budget);
    logic [31:0] heldData;
    logic        heldLast;
    bit          holding;
    nIssued = 0; nGot = 0; holding = 0; heldData = '0; heldLast = 1'b0;
    rspReady = 1'b0;
    for (int cyc = 0; cyc < budget && nGot < maxWords; cyc++) begin
      if (bramEn === 1'b1 && nIssued < 16) begin
        issued[nIssued] = bramAddr;
        nIssued++;
        checkCount++; if (bramWe === 4'h0) passCount++;
        else $display("[TB] FAIL read_we_zero: got %h expected 0", bramWe);
      end
      if (rspValid === 1'b1) begin
        if (holding) begin
          checkCount++; if (rspRdata === heldData && rspLast === heldLast) passCount++;
          else $display("[TB] FAIL stall_stable: got %h/%b expected %h/%b", rspRdata, rspLast, heldData, heldLast);
        end
        rspReady = stall ? holding : 1'b1;
        if (rspReady) begin
          got[nGot] = rspRdata;
          gotLast[nGot] = rspLast;
          nGot++;
          holding = 0;
        end else begin
          holding = 1; heldData = rspRdata; heldLast = rspLast;
        end
      end
      if (nGot < maxWords) tick();
    end
    tick();
    rspReady = 1'b0;
  endtask

  task automatic test_reset();
    reqValid = 1'b1; reqWe = 4'h0; hostRstn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkCount++; if (reqReady === 1'b0) passCount++;
      else $display("[TB] FAIL reset_req_ready cyc%0d: got %b expected 0", i, reqReady);
      checkCount++; if (bramEn === 1'b0) passCount++;
      else $display("[TB] FAIL reset_bram_en cyc%0d: got %b expected 0", i, bramEn);
      checkCount++; if (rspValid === 1'b0) passCount++;
      else $display("[TB] FAIL reset_rsp_valid cyc%0d: got %b expected 0", i, rspValid);
    end
    checkCount++; if (bramRst === 1'b1) passCount++;
    else $display("[TB] FAIL reset_bram_rst: got %b expected 1", bramRst);
    reqValid = 1'b0;
    hostRstn = 1'b1;
    tick();
    checkCount++; if (reqReady === 1'b1 && bramRst === 1'b0) passCount++;
    else $display("[TB] FAIL release_ready: got %b/%b expected 1/0", reqReady, bramRst);
  endtask

  task automatic test_write();
    sendReq(4'hF, 15'h0104, 8'd0, 32'hDEADBEEF);
    checkCount++; if (bramEn === 1'b1 && bramWe === 4'hF) passCount++;
    else $display("[TB] FAIL write_en_we: got %b/%h expected 1/f", bramEn, bramWe);
    checkCount++; if (bramAddr === 15'h0104) passCount++;
    else $display("[TB] FAIL write_addr: got %h expected 0104", bramAddr);
    checkCount++; if (bramDin === 32'hDEADBEEF) passCount++;
    else $display("[TB] FAIL write_din: got %h expected deadbeef", bramDin);
    checkCount++; if (reqReady === 1'b0) passCount++;
    else $display("[TB] FAIL write_busy: got %b expected 0", reqReady);
    tick();
    checkCount++; if (bramEn === 1'b0 && bramWe === 4'h0) passCount++;
    else $display("[TB] FAIL write_one_cycle: got %b/%h expected 0/0", bramEn, bramWe);
    checkCount++; if (reqReady === 1'b1 && rspValid === 1'b0) passCount++;
    else $display("[TB] FAIL write_done: got %b/%b expected 1/0", reqReady, rspValid);
    sendReq(4'hF, 15'h0013, 8'd0, 32'h12345678);
    checkCount++; if (bramAddr === 15'h0010) passCount++;
    else $display("[TB] FAIL write_align: got %h expected 0010", bramAddr);
    tick();
  endtask

  task automatic test_back_to_back();
    reqValid = 1'b1; reqWe = 4'b0011; reqAddr = 15'h0104; reqWdata = 32'h0000CAFE;
    tick();
    checkCount++; if (bramEn === 1'b1 && bramAddr === 15'h0104 && bramWe === 4'b0011) passCount++;
    else $display("[TB] FAIL b2b_first: got %b/%h/%h expected 1/0104/3", bramEn, bramAddr, bramWe);
    reqWe = 4'b1100; reqAddr = 15'h0400; reqWdata = 32'h5A5A0000;
    tick();
    checkCount++; if (bramEn === 1'b0 && reqReady === 1'b1) passCount++;
    else $display("[TB] FAIL b2b_gap: got %b/%b expected 0/1", bramEn, reqReady);
    tick();
    reqValid = 1'b0;
    checkCount++; if (bramEn === 1'b1 && bramAddr === 15'h0400 && bramDin === 32'h5A5A0000) passCount++;
    else $display("[TB] FAIL b2b_second: got %b/%h/%h expected 1/0400/5a5a0000", bramEn, bramAddr, bramDin);
    tick();
    sendReq(4'h0, 15'h0104, 8'd0, 32'h0);
    collectRead(1, 1'b0, 50);
    checkCount++; if (nGot == 1 && got[0] === 32'hDEADCAFE) passCount++;
    else $display("[TB] FAIL b2b_readback0: got %0d/%h expected 1/deadcafe", nGot, got[0]);
    sendReq(4'h0, 15'h0400, 8'd0, 32'h0);
    collectRead(1, 1'b0, 50);
    checkCount++; if (nGot == 1 && got[0] === 32'h5A5A0400) passCount++;
    else $display("[TB] FAIL b2b_readback1: got %0d/%h expected 1/5a5a0400", nGot, got[0]);
  endtask

  task automatic test_read_single();
    sendReq(4'h0, 15'h0010, 8'd0, 32'h0);
    checkCount++; if (bramEn === 1'b1 && bramWe === 4'h0 && bramAddr === 15'h0010) passCount++;
    else $display("[TB] FAIL rd_issue: got %b/%h/%h expected 1/0/0010", bramEn, bramWe, bramAddr);
    tick();
    checkCount++; if (bramEn === 1'b0 && rspValid === 1'b0) passCount++;
    else $display("[TB] FAIL rd_t1: got %b/%b expected 0/0", bramEn, rspValid);
    tick();
    checkCount++; if (rspValid === 1'b0) passCount++;
    else $display("[TB] FAIL rd_t2: got %b expected 0", rspValid);
    tick();
    checkCount++; if (rspValid === 1'b1 && rspLast === 1'b1) passCount++;
    else $display("[TB] FAIL rd_t3_valid: got %b/%b expected 1/1", rspValid, rspLast);
    checkCount++; if (rspRdata === 32'h12345678) passCount++;
    else $display("[TB] FAIL rd_t3_data: got %h expected 12345678", rspRdata);
    rspReady = 1'b1;
    tick();
    rspReady = 1'b0;
    checkCount++; if (rspValid === 1'b0 && reqReady === 1'b1) passCount++;
    else $display("[TB] FAIL rd_done: got %b/%b expected 0/1", rspValid, reqReady);
  endtask

  task automatic test_burst();
    logic [14:0] expAddr [4];
    logic [31:0] expData [4];
    expAddr = '{15'h0200, 15'h0204, 15'h0208, 15'h020C};
    expData = '{32'hC0DE0200, 32'hC0DE0204, 32'hC0DE0208, 32'hC0DE020C};
    sendReq(4'h0, 15'h0200, 8'd3, 32'h0);
    collectRead(4, 1'b1, 200);
    checkCount++; if (nGot == 4 && nIssued == 4) passCount++;
    else $display("[TB] FAIL burst_count: got %0d words %0d issues expected 4/4", nGot, nIssued);
    for (int k = 0; k < 4; k++) begin
      checkCount++; if (issued[k] === expAddr[k]) passCount++;
      else $display("[TB] FAIL burst_addr%0d: got %h expected %h", k, issued[k], expAddr[k]);
      checkCount++; if (got[k] === expData[k] && gotLast[k] === (k == 3)) passCount++;
      else $display("[TB] FAIL burst_word%0d: got %h/%b expected %h/%b", k, got[k], gotLast[k], expData[k], k == 3);
    end
    checkCount++; if (rspValid === 1'b0 && reqReady === 1'b1) passCount++;
    else $display("[TB] FAIL burst_done: got %b/%b expected 0/1", rspValid, reqReady);
  endtask

  task automatic test_wrap();
    sendReq(4'h0, 15'h7FFE, 8'd1, 32'h0);
    collectRead(2, 1'b0, 100);
    checkCount++; if (nIssued == 2 && issued[0] === 15'h7FFC && issued[1] === 15'h0000) passCount++;
    else $display("[TB] FAIL wrap_addr: got %0d %h %h expected 2 7ffc 0000", nIssued, issued[0], issued[1]);
    checkCount++; if (nGot == 2 && got[0] === 32'hC0DE7FFC && got[1] === 32'hC0DE0000) passCount++;
    else $display("[TB] FAIL wrap_data: got %0d %h %h expected 2 c0de7ffc c0de0000", nGot, got[0], got[1]);
    checkCount++; if (gotLast[0] === 1'b0 && gotLast[1] === 1'b1) passCount++;
    else $display("[TB] FAIL wrap_last: got %b%b expected 01", gotLast[0], gotLast[1]);
  endtask

  task automatic test_reset_mid_burst();
    bit activity;
    sendReq(4'h0, 15'h0300, 8'd7, 32'h0);
    collectRead(2, 1'b0, 100);
    checkCount++; if (nGot == 2 && got[0] === 32'hC0DE0300 && got[1] === 32'hC0DE0304) passCount++;
    else $display("[TB] FAIL midrst_words: got %0d %h %h expected 2 c0de0300 c0de0304", nGot, got[0], got[1]);
    hostRstn = 1'b0;
    tick();
    checkCount++; if (reqReady === 1'b0 && bramEn === 1'b0 && rspValid === 1'b0 && rspLast === 1'b0) passCount++;
    else $display("[TB] FAIL midrst_ctrl: got %b%b%b%b expected 0000", reqReady, bramEn, rspValid, rspLast);
    checkCount++; if (bramWe === 4'h0 && bramAddr === 15'h0 && bramDin === 32'h0 && rspRdata === 32'h0) passCount++;
    else $display("[TB] FAIL midrst_data: got %h/%h/%h/%h expected zeros", bramWe, bramAddr, bramDin, rspRdata);
    tick();
    hostRstn = 1'b1;
    tick();
    checkCount++; if (reqReady === 1'b1) passCount++;
    else $display("[TB] FAIL midrst_ready: got %b expected 1", reqReady);
    activity = 0;
    rspReady = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (rspValid !== 1'b0 || bramEn !== 1'b0) activity = 1;
      tick();
    end
    rspReady = 1'b0;
    checkCount++; if (activity == 0) passCount++;
    else $display("[TB] FAIL midrst_quiet: got activity 1 expected 0");
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) written[i] = 1'b0;
    test_reset();
    test_write();
    test_back_to_back();
    test_read_single();
    test_burst();
    test_wrap();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
